sme_param: RTL
==============

Name: sme_param

Overview:
- Parametrised successor to the string matching engine (SME).
- Stores one string of up to STR_MAX characters and matches patterns of up to PAT_MAX characters against it.
- Pattern wildcards: '.' (any character), '^' (word/string start anchor), '$' (word/string end anchor).
- Adds case-insensitive mode, total match count and fixed-latency result reporting. Loaded string persists across any number of patterns.

Parameters:
- STR_MAX, 32, maximum stored string length in characters.
- PAT_MAX, 8, maximum pattern length including anchor characters.
- IDX_W, $clog2(STR_MAX), width of match_index.
- CNT_W, $clog2(STR_MAX+1), width of match_count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- chardata  in  8  ASCII character, one per cycle while isstring or ispattern is high.
- isstring  in  1  high for each string character; a new string replaces the stored one.
- ispattern  in  1  high for each pattern character.
- nocase  in  1  sampled on the first ispattern cycle; 1 = compare letters A-Z/a-z case-insensitively.
- valid  out  1  one-cycle pulse; match, match_index and match_count are valid in this cycle.
- match  out  1  1 = at least one match position found.
- match_index  out  IDX_W  index of string character aligned with the first non-'^' pattern character, at the lowest matching position; 0 if no match.
- match_count  out  CNT_W  number of distinct matching start positions.

Behaviour:
- Reset: all outputs 0; state IDLE; stored length L=0; pattern length P=0.
- States: IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE.
- IDLE -> LOAD_STR on isstring. IDLE -> LOAD_PAT on ispattern.
- LOAD_STR: each isstring cycle writes str[L], L++. Characters beyond STR_MAX are dropped and L saturates at STR_MAX. Exit to IDLE when isstring falls.
- LOAD_PAT: same rule on pat[]. P saturates at PAT_MAX. Exit to SEARCH when ispattern falls.
- If isstring and ispattern are both high, isstring wins and chardata is stored as string data.
- Pattern preprocessing:
  - Leading '^' (0x5E) sets anchor_s and is stripped.
  - Trailing '$' (0x24) sets anchor_e and is stripped.
  - Remaining body length B.
- SEARCH: one start position s per cycle, s = 0..L-1, body compared in parallel. Position s matches iff all of:
  - s+B <= L;
  - every body char k is '.' (0x2E) or equals str[s+k] (case-folded if nocase);
  - anchor_s implies s==0 or str[s-1]==0x20;
  - anchor_e implies s+B==L or str[s+B]==0x20.
- Counting: the first matching s is latched as the index; match_count increments per matching s and saturates at STR_MAX.
- Degenerate cases: B==0 or L==0 gives match=0, count=0. Scan still runs L cycles (0 if L==0).
- DONE: valid=1 for exactly one cycle, then IDLE.
  - Latency: valid asserts exactly L+2 cycles after the first cycle ispattern is low.
  - Outputs hold their values until the next valid.
- Inputs isstring/ispattern are ignored in SEARCH and DONE; the driver must not assert them there.
- Reset mid-operation (any state) returns to IDLE next edge, clears L, P and outputs, and suppresses valid.
- The '.', '^' and '$' characters in the string are literal. '^' or '$' inside the pattern body are literal.
- nocase folds only 0x41-0x5A vs 0x61-0x7A; no other characters fold.

Test Plan:
- String "hello world" (L=11), pattern "wor" -> valid 13 cycles after ispattern falls; match=1, index=6, count=1.
- Same string, pattern "o" -> match=1, index=4, count=2. Pattern "^w.r" -> 1, 6, 1.
- Same string, pattern "lo$" -> match=1, index=3, count=1. Pattern "xyz" -> 0, 0, 0. Pattern "^$" -> 0, 0, 0.
- nocase=1, pattern "WORLD$" -> 1, 6, 1; nocase=0, same pattern -> 0, 0, 0.
- STR_MAX=32, 40-char string of 'a', pattern "aa" -> L=32, match=1, index=0, count=31, valid at cycle 34.
- Reset asserted in SEARCH cycle 3 -> no valid pulse. A following pattern "abc" with no string reloaded -> L=0, valid 2 cycles after ispattern falls, match=0.

Source files
------------

// File: rtl/sme_param_if.sv
// Bus bundle for sme_param: one character per cycle inward, one result pulse outward.
// Handshake: the driver presents chardata with isstring or ispattern high (no back-pressure);
// the engine raises valid for exactly one cycle when match/match_index/match_count are fresh.
interface sme_param_if #(
  parameter int IDX_W = 5,
  parameter int CNT_W = 6
);
   logic [7:0]       chardata;
   logic             isstring;
   logic             ispattern;
   logic             nocase;
   logic             valid;
   logic             match;
   logic [IDX_W-1:0] match_index;
   logic [CNT_W-1:0] match_count;
   logic [2:0]       dbg_state;

   modport master (
      output chardata, isstring, ispattern, nocase,
      input  valid, match, match_index, match_count, dbg_state
   );

   modport slave (
      input  chardata, isstring, ispattern, nocase,
      output valid, match, match_index, match_count, dbg_state
   );
endinterface

// File: rtl/sme_param.sv
// String matching engine: stores a string, then scans one start position per cycle
// against a pattern with '.', '^' and '$' wildcards, optionally case-insensitive.
module sme_param #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int IDX_W   = $clog2(STR_MAX),
   parameter int CNT_W   = $clog2(STR_MAX + 1)
) (
   input logic        clk,
   input logic        reset,
   sme_param_if.slave bus
);
   localparam int PW = $clog2(PAT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_STR, S_LOAD_PAT, S_SEARCH, S_DONE
   } state_t;

   state_t           r_state, w_next;
   logic [7:0]       r_str [STR_MAX];
   logic [7:0]       r_pat [PAT_MAX];
   logic [CNT_W-1:0] r_len, r_s, r_cnt, r_count;
   logic [PW-1:0]    r_plen;
   logic             r_nocase, r_found, r_match;
   logic [IDX_W-1:0] r_first, r_index;
   logic             w_str_we, w_pat_we, w_hit;
   int               w_str_wa, w_pat_wa;

   function automatic logic [7:0] fold(input logic [7:0] c);
      fold = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
   endfunction

   function automatic logic [7:0] str_at(input int idx);
      str_at = 8'h00;
      for (int j = 0; j < STR_MAX; j++) if (j == idx) str_at = r_str[j];
   endfunction

   function automatic logic [7:0] pat_at(input int idx);
      pat_at = 8'h00;
      for (int j = 0; j < PAT_MAX; j++) if (j == idx) pat_at = r_pat[j];
   endfunction

   always_comb begin
      w_next   = r_state;
      w_str_we = 1'b0;
      w_pat_we = 1'b0;
      w_str_wa = (r_state == S_IDLE) ? 0 : int'(r_len);
      w_pat_wa = (r_state == S_IDLE) ? 0 : int'(r_plen);
      unique case (r_state)
         S_IDLE: begin
            if (bus.isstring) begin
               w_next   = S_LOAD_STR;
               w_str_we = 1'b1;
            end else if (bus.ispattern) begin
               w_next   = S_LOAD_PAT;
               w_pat_we = 1'b1;
            end
         end
         S_LOAD_STR: begin
            if (!bus.isstring) w_next = S_IDLE;
            else               w_str_we = (int'(r_len) < STR_MAX);
         end
         S_LOAD_PAT: begin
            if (!bus.ispattern)    w_next = S_SEARCH;
            else if (bus.isstring) w_str_we = (int'(r_len) < STR_MAX);
            else                   w_pat_we = (int'(r_plen) < PAT_MAX);
         end
         S_SEARCH: if (r_s == r_len) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Match test for start position r_s; anchors are stripped off the pattern ends here.
   always_comb begin : hit_calc
      int p, l, s, as_i, ae_i, b;
      logic [7:0] pc, sc;
      p    = int'(r_plen);
      l    = int'(r_len);
      s    = int'(r_s);
      as_i = (p > 0 && r_pat[0] == 8'h5E) ? 1 : 0;
      ae_i = (p > as_i && pat_at(p - 1) == 8'h24) ? 1 : 0;
      b    = p - as_i - ae_i;
      w_hit = (b > 0) && (s < l) && (s + b <= l);
      pc = 8'h00;
      sc = 8'h00;
      for (int k = 0; k < PAT_MAX; k++) begin
         if (k < b) begin
            pc = pat_at(as_i + k);
            sc = str_at(s + k);
            if (pc != 8'h2E && (r_nocase ? (fold(pc) != fold(sc)) : (pc != sc))) w_hit = 1'b0;
         end
      end
      if (as_i == 1 && s != 0 && str_at(s - 1) != 8'h20) w_hit = 1'b0;
      if (ae_i == 1 && s + b != l && str_at(s + b) != 8'h20) w_hit = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_len    <= '0;
         r_plen   <= '0;
         r_nocase <= 1'b0;
         r_s      <= '0;
         r_found  <= 1'b0;
         r_first  <= '0;
         r_cnt    <= '0;
         r_match  <= 1'b0;
         r_index  <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_next;
         if (w_str_we) begin
            for (int j = 0; j < STR_MAX; j++) if (j == w_str_wa) r_str[j] <= bus.chardata;
            r_len <= (r_state == S_IDLE) ? CNT_W'(1) : r_len + CNT_W'(1);
         end
         if (w_pat_we) begin
            for (int j = 0; j < PAT_MAX; j++) if (j == w_pat_wa) r_pat[j] <= bus.chardata;
            r_plen <= (r_state == S_IDLE) ? PW'(1) : r_plen + PW'(1);
            if (r_state == S_IDLE) r_nocase <= bus.nocase;
         end
         if (r_state == S_LOAD_PAT && !bus.ispattern) begin
            r_s     <= '0;
            r_found <= 1'b0;
            r_first <= '0;
            r_cnt   <= '0;
         end
         // Position L is a drain cycle: the last position's result lands in the accumulators first.
         if (r_state == S_SEARCH) begin
            if (r_s == r_len) begin
               r_match <= r_found;
               r_index <= r_first;
               r_count <= r_cnt;
            end else begin
               r_s <= r_s + CNT_W'(1);
               if (w_hit) begin
                  if (int'(r_cnt) < STR_MAX) r_cnt <= r_cnt + CNT_W'(1);
                  if (!r_found) begin
                     r_found <= 1'b1;
                     r_first <= r_s[IDX_W-1:0];
                  end
               end
            end
         end
      end
   end

   assign bus.valid       = (r_state == S_DONE);
   assign bus.match       = r_match;
   assign bus.match_index = r_index;
   assign bus.match_count = r_count;
   assign bus.dbg_state   = r_state;
endmodule
